// File: rtl/if_stage.sv
// Instruction-fetch stage with the IF/ID pipeline register for the 5-stage MIPS core.
// Optional perf counters (fetch_cnt, bubble_cnt) are built when IF_PERF_CNT_EN is defined.
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [1:0]        pcsource,
  input  logic [ADDR_W-1:0] rpc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  output logic [ADDR_W-1:0] pc,
  output logic [31:0]       id_inst,
  output logic [ADDR_W-1:0] id_pc4,
  output logic              id_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [31:0]       id_inst_q, id_inst_d;
  logic [ADDR_W-1:0] id_pc4_q, id_pc4_d;
  logic              id_valid_q, id_valid_d;

  logic [ADDR_W-1:0] seq_pc, bpc, jpc, rtgt;
  logic              redirect;

  always_comb begin
    seq_pc   = pc_q + 32'd4;
    bpc      = id_pc4_q + {{14{id_inst_q[15]}}, id_inst_q[15:0], 2'b00};
    jpc      = {id_pc4_q[31:28], id_inst_q[25:0], 2'b00};
    rtgt     = rpc & ~32'h0000_0003;
    redirect = (pcsource != 2'd0);

    pc_d       = pc_q;
    id_inst_d  = id_inst_q;
    id_pc4_d   = id_pc4_q;
    id_valid_d = id_valid_q;

    // Stall freezes everything; a redirect squashes the wrong-path word fetched this cycle.
    if (!stall) begin
      if (redirect) begin
        case (pcsource)
          2'd1:    pc_d = bpc;
          2'd2:    pc_d = rtgt;
          default: pc_d = jpc;
        endcase
        id_inst_d  = 32'h0;
        id_pc4_d   = '0;
        id_valid_d = 1'b0;
      end else begin
        pc_d       = seq_pc;
        id_inst_d  = imem_rdata;
        id_pc4_d   = seq_pc;
        id_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q       <= RESET_PC;
      id_inst_q  <= 32'h0;
      id_pc4_q   <= '0;
      id_valid_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      id_inst_q  <= id_inst_d;
      id_pc4_q   <= id_pc4_d;
      id_valid_q <= id_valid_d;
    end
  end

  assign imem_addr = pc_q;
  assign pc        = pc_q;
  assign id_inst   = id_inst_q;
  assign id_pc4    = id_pc4_q;
  assign id_valid  = id_valid_q;

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q  + {31'b0, (!stall && !redirect)};
    bubble_cnt_d = bubble_cnt_q + {31'b0, (stall || redirect)};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt_q  <= 32'h0;
      bubble_cnt_q <= 32'h0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt  = fetch_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized and directed bench for if_stage against a rule-level fetch model.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic [1:0]  pcsource = 2'd0;
  logic [31:0] rpc = 32'h0;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic [31:0] id_inst;
  logic [31:0] id_pc4;
  logic        id_valid;
`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] bubble_cnt;
`endif

  if_stage #(.RESET_PC(RESET_PC), .ADDR_W(32)) dut (
    .clk(clk), .rst(rst), .stall(stall), .pcsource(pcsource), .rpc(rpc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .id_inst(id_inst), .id_pc4(id_pc4), .id_valid(id_valid)
`ifdef IF_PERF_CNT_EN
    , .fetch_cnt(fetch_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          failures = 0;
  int          mem_mode = 0;
  logic [31:0] seed = 32'h5A5A_1234;
  logic        ovr_en = 1'b0;
  logic [31:0] ovr_word = 32'h0;

  function automatic logic [31:0] mem_fn(input logic [31:0] a);
    if (mem_mode == 0) return a;
    return (a * 32'h9E37_79B1) ^ seed;
  endfunction

  always_comb imem_rdata = ovr_en ? ovr_word : mem_fn(imem_addr);

  // Reference model state
  logic [31:0] m_pc, m_inst, m_pc4, m_fetch, m_bub;
  logic        m_valid;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic st, input logic [1:0] ps, input logic [31:0] rv,
                      input logic oe, input logic [31:0] ow, input logic r);
    logic [31:0] word, tgt, imm_ext;
    @(negedge clk);
    rst = r; stall = st; pcsource = ps; rpc = rv; ovr_en = oe; ovr_word = ow;
    #1;
    if (!$isunknown(m_pc)) check("imem_addr", imem_addr, m_pc);
    word = oe ? ow : mem_fn(m_pc);
    if (r) begin
      m_pc = RESET_PC; m_inst = 0; m_pc4 = 0; m_valid = 0; m_fetch = 0; m_bub = 0;
    end else if (st) begin
      m_bub = m_bub + 1;
    end else if (ps != 2'd0) begin
      imm_ext = 32'($signed(m_inst[15:0]));
      case (ps)
        2'd1:    tgt = m_pc4 + imm_ext * 4;
        2'd2:    tgt = (rv / 4) * 4;
        default: tgt = (m_pc4 & 32'hF000_0000) + (m_inst % 32'h0400_0000) * 4;
      endcase
      m_pc = tgt; m_inst = 0; m_pc4 = 0; m_valid = 0; m_bub = m_bub + 1;
    end else begin
      m_pc = m_pc + 4; m_inst = word; m_pc4 = m_pc; m_valid = 1; m_fetch = m_fetch + 1;
    end
    @(posedge clk);
    #1;
    check("pc", pc, m_pc);
    check("id_inst", id_inst, m_inst);
    check("id_pc4", id_pc4, m_pc4);
    check("id_valid", {31'b0, id_valid}, {31'b0, m_valid});
`ifdef IF_PERF_CNT_EN
    check("fetch_cnt", fetch_cnt, m_fetch);
    check("bubble_cnt", bubble_cnt, m_bub);
`endif
  endtask

  task automatic seq_step();
    step(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    m_pc = 'x; m_inst = 0; m_pc4 = 0; m_valid = 0; m_fetch = 0; m_bub = 0;

    // Reset and free-running fetch with word = address
    step(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("rst_pc", pc, RESET_PC);
    check("rst_valid", {31'b0, id_valid}, 32'h0);
    check("rst_inst", id_inst, 32'h0);
    for (int i = 1; i <= 4; i++) begin
      seq_step();
      check("t1_pc", pc, 32'(i * 4));
      check("t1_inst", id_inst, 32'((i - 1) * 4));
      check("t1_valid", {31'b0, id_valid}, 32'h1);
    end

    // Backward branch: beq imm=-2 with id_pc4=0x20
    for (int i = 0; i < 3; i++) seq_step();
    check("t2_pc_pre", pc, 32'h1C);
    step(1'b0, 2'd0, 32'h0, 1'b1, 32'h1000_FFFE, 1'b0);
    check("t2_pc4", id_pc4, 32'h20);
    step(1'b0, 2'd1, 32'h0, 1'b0, 32'h0, 1'b0);
    check("t2_bpc", pc, 32'h18);
    check("t2_bubble", id_inst, 32'h0);
    seq_step();
    check("t2_resume_inst", id_inst, 32'h18);
    check("t2_resume_pc", pc, 32'h1C);

    // Jump into upper region, then jr with misaligned rpc
    step(1'b0, 2'd2, 32'h8000_000C, 1'b0, 32'h0, 1'b0);
    step(1'b0, 2'd0, 32'h0, 1'b1, 32'h0800_0100, 1'b0);
    check("t3_pc4", id_pc4, 32'h8000_0010);
    step(1'b0, 2'd3, 32'h0, 1'b0, 32'h0, 1'b0);
    check("t3_jpc", pc, 32'h8000_0400);
    seq_step();
    step(1'b0, 2'd2, 32'h0000_1237, 1'b0, 32'h0, 1'b0);
    check("t3_rtgt", pc, 32'h0000_1234);

    // Stall with pending branch, then branch taken on release
    seq_step();
    step(1'b0, 2'd2, 32'h0000_003C, 1'b0, 32'h0, 1'b0);
    step(1'b0, 2'd0, 32'h0, 1'b1, 32'h1000_0004, 1'b0);
    check("t4_pc_pre", pc, 32'h40);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 2'd1, 32'h0, 1'b0, 32'h0, 1'b0);
      check("t4_hold_pc", pc, 32'h40);
      check("t4_hold_inst", id_inst, 32'h1000_0004);
      check("t4_hold_pc4", id_pc4, 32'h40);
    end
    step(1'b0, 2'd1, 32'h0, 1'b0, 32'h0, 1'b0);
    check("t4_release_pc", pc, 32'h50);

    // PC wrap, then reset beating stall and redirect
    seq_step();
    step(1'b0, 2'd2, 32'hFFFF_FFFF, 1'b0, 32'h0, 1'b0);
    check("t5_pc_top", pc, 32'hFFFF_FFFC);
    seq_step();
    check("t5_wrap_pc", pc, 32'h0);
    check("t5_wrap_pc4", id_pc4, 32'h0);
    check("t5_wrap_valid", {31'b0, id_valid}, 32'h1);
    step(1'b1, 2'd3, 32'h0, 1'b0, 32'h0, 1'b1);
    check("t5_rst_pc", pc, RESET_PC);
    check("t5_rst_valid", {31'b0, id_valid}, 32'h0);
    check("t5_rst_inst", id_inst, 32'h0);

    // Counter scenario: 5 fetches, 1 redirect, 2 stalls
    for (int i = 0; i < 5; i++) seq_step();
    step(1'b0, 2'd2, 32'h0000_0100, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 2'd0, 32'h0, 1'b0, 32'h0, 1'b0);
`ifdef IF_PERF_CNT_EN
    check("t6_fetch", fetch_cnt, 32'd5);
    check("t6_bubble", bubble_cnt, 32'd3);
    step(1'b0, 2'd0, 32'h0, 1'b0, 32'h0, 1'b1);
    check("t6_rst_fetch", fetch_cnt, 32'd0);
    check("t6_rst_bubble", bubble_cnt, 32'd0);
`endif

    // Randomized traffic; redirects only from a real instruction in ID
    mem_mode = 1;
    seed = $urandom;
    for (int i = 0; i < 400; i++) begin
      logic        r_st, r_rst, r_oe;
      logic [1:0]  r_ps;
      r_rst = ($urandom_range(0, 49) == 0);
      r_st  = ($urandom_range(0, 4) == 0);
      r_ps  = (m_valid && $urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      r_oe  = ($urandom_range(0, 3) == 0);
      step(r_st, r_ps, $urandom, r_oe, $urandom, r_rst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
